rule_writer: RTL

Downstream stage of the parser in the core. Accepts the 16-bit reduction rules the parser emits (O_VALID/O_RULE) and packs two rules per 32-bit word, low half first. Buffers the packed words in a small FIFO and writes them out sequentially via single-beat AXI4 writes on the master AW/W/B channels, which the core currently ties off. Gives the host a linear rule trace in memory starting at a programmable base address.

---
 rtl/rule_writer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rule_writer.sv
// Packs 16-bit parser reduction rules two per 32-bit word (low half first), queues
// the words and writes them out as single-beat AXI4 writes to consecutive addresses.
module rule_writer #(
    parameter int          FIFO_DEPTH         = 16,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [15:0] PAD_RULE           = 16'hFFFF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          I_START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_BASE_ADDR,
    input  logic                          I_VALID,
    input  logic [15:0]                   I_RULE,
    input  logic                          I_FLUSH,
    output logic                          O_READY,
    output logic                          O_IDLE,
    output logic [31:0]                   O_COUNT,
    output logic                          O_ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]                    r_state;
    logic [31:0]                   r_mem [FIFO_DEPTH];
    logic [PW:0]                   r_wptr;
    logic [PW:0]                   r_rptr;
    logic                          r_half;
    logic [15:0]                   r_lo;
    logic                          r_flush_pend;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]                   r_wdata;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic [31:0]                   r_count;
    logic                          r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_idle;
    logic        w_push;
    logic [31:0] w_push_data;
    logic        w_half_nxt;
    logic [15:0] w_lo_nxt;
    logic        w_flush_nxt;
    logic        w_aw_done;
    logic        w_w_done;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_accept = I_VALID && !w_full;
    assign w_idle   = (r_state == S_IDLE) && w_empty && !r_half && !r_flush_pend;

    // Ordering within a cycle: a flush left over from an earlier (full) cycle goes
    // first, then the incoming rule, then this cycle's flush. At most one push per cycle.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_half_nxt  = r_half;
        w_lo_nxt    = r_lo;
        w_flush_nxt = r_flush_pend;
        if (r_flush_pend) begin
            if (!r_half) begin
                w_flush_nxt = 1'b0;
            end else if (!w_full) begin
                w_push      = 1'b1;
                w_push_data = {PAD_RULE, r_lo};
                w_half_nxt  = 1'b0;
                w_flush_nxt = 1'b0;
            end
        end
        if (w_accept) begin
            if (!w_half_nxt) begin
                w_lo_nxt   = I_RULE;
                w_half_nxt = 1'b1;
            end else begin
                w_push      = 1'b1;
                w_push_data = {I_RULE, r_lo};
                w_half_nxt  = 1'b0;
            end
        end
        if (I_FLUSH && w_half_nxt) begin
            if (!w_push && !w_full) begin
                w_push      = 1'b1;
                w_push_data = {PAD_RULE, w_lo_nxt};
                w_half_nxt  = 1'b0;
                w_flush_nxt = 1'b0;
            end else begin
                w_flush_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_half       <= 1'b0;
            r_lo         <= '0;
            r_flush_pend <= 1'b0;
            r_wptr       <= '0;
        end else begin
            r_half       <= w_half_nxt;
            r_lo         <= w_lo_nxt;
            r_flush_pend <= w_flush_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= w_push_data;
        end
    end

    // A channel counts as done once its VALID is already low or handshakes this cycle.
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid || M_AXI_WREADY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rptr    <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_addr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_awaddr  <= r_addr;
                        r_wdata   <= r_mem[r_rptr[PW-1:0]];
                        r_rptr    <= r_rptr + 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_addr   <= r_addr + C_M_AXI_ADDR_WIDTH'(4);
                        if (r_count != 32'hFFFF_FFFF) begin
                            r_count <= r_count + 32'd1;
                        end
                        r_err   <= r_err | (M_AXI_BRESP != 2'b00);
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (I_START && w_idle) begin
                r_addr  <= I_BASE_ADDR;
                r_count <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign O_READY       = !w_full;
    assign O_IDLE        = w_idle;
    assign O_COUNT       = r_count;
    assign O_ERROR       = r_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;

endmodule
